// File: rtl/cmul_arbiter.sv
// Round-robin share of one int/FP multiplier pair between two requesters; response valid MUL_LAT edges after acceptance.
// Single outstanding op: both readys drop outside IDLE; the response register holds until rsp_ready.
module cmul_arbiter #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] mul_int_a,
  output logic [31:0] mul_int_b,
  input  logic [63:0] mul_int_c,
  output logic [31:0] mul_fp_a,
  output logic [31:0] mul_fp_b,
  input  logic [31:0] mul_fp_c,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic        rsp_op,
  output logic [63:0] rsp_int,
  output logic [31:0] rsp_fp,
  output logic        busy,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  state_t      state_q, state_d;
  logic        last_grant_q;
  logic [3:0]  cnt_q;
  logic        id_q, op_q;
  logic        gnt0, gnt1, accept, capture, rsp_done;
  logic        sel_op;
  logic [31:0] sel_a, sel_b;

  // last_grant_q = 1 means req1 was served last, so req0 wins a tie.
  always_comb begin
    gnt0       = req0_valid & (~req1_valid | last_grant_q);
    gnt1       = req1_valid & (~req0_valid | ~last_grant_q);
    req0_ready = (state_q == IDLE) & gnt0;
    req1_ready = (state_q == IDLE) & gnt1;
    accept     = req0_ready | req1_ready;
    sel_op     = gnt1 ? req1_op : req0_op;
    sel_a      = gnt1 ? req1_a  : req0_a;
    sel_b      = gnt1 ? req1_b  : req0_b;
    capture    = (state_q == EXEC) && (cnt_q == 4'd0);
    rsp_done   = (state_q == RESP) && rsp_ready;
    busy       = (state_q != IDLE);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)   state_d = EXEC;
      EXEC:    if (capture)  state_d = RESP;
      RESP:    if (rsp_done) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      id_q         <= 1'b0;
      op_q         <= 1'b0;
      mul_int_a    <= '0;
      mul_int_b    <= '0;
      mul_fp_a     <= '0;
      mul_fp_b     <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_op       <= 1'b0;
      rsp_int      <= '0;
      rsp_fp       <= '0;
      op_count     <= '0;
    end else begin
      if (accept) begin
        // Zero the unused unit's operands so it does not toggle.
        mul_int_a    <= sel_op ? 32'd0 : sel_a;
        mul_int_b    <= sel_op ? 32'd0 : sel_b;
        mul_fp_a     <= sel_op ? sel_a : 32'd0;
        mul_fp_b     <= sel_op ? sel_b : 32'd0;
        id_q         <= gnt1;
        op_q         <= sel_op;
        last_grant_q <= gnt1;
        cnt_q        <= CNT_INIT;
      end
      if (state_q == EXEC) begin
        if (capture) begin
          rsp_valid <= 1'b1;
          rsp_id    <= id_q;
          rsp_op    <= op_q;
          rsp_int   <= op_q ? 64'd0 : mul_int_c;
          rsp_fp    <= op_q ? mul_fp_c : 32'd0;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
      end
      if (rsp_done) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + 16'd1;
      end
    end
  end

endmodule
